seq_multiplier: RTL and testbench
=================================

Name: seq_multiplier

Overview:
- Iterative shift-add multiplier in the Execution stage, beside the ALU.
- Serves MUL/MULH-class instructions that the single-cycle ALU cannot complete in one cycle.
- Takes two WORD operands under a start/done handshake and produces a 2×WORD product.
- Stalls the pipeline via o_busy while the multiply runs.

Parameters:
- WORD_WIDTH, 32, operand width in bits (power of two, ≥4); result is 2×WORD_WIDTH.
- CNT_WIDTH, log2(WORD_WIDTH)+1, width of the iteration counter.

Ports:
- i_clk  input  1  clock; all state updates on rising edge.
- i_rst  input  1  asynchronous active-high reset.
- i_start  input  1  request; accepted only in IDLE.
- i_signed  input  1  1 = two's-complement operands; 0 = unsigned. Sampled with i_start.
- i_A  input  WORD_WIDTH  multiplicand, sampled with i_start.
- i_B  input  WORD_WIDTH  multiplier, sampled with i_start.
- o_busy  output  1  high in RUN, FIX and DONE.
- o_done  output  1  one-cycle pulse; results valid.
- o_productLo  output  WORD_WIDTH  low word of the product.
- o_productHi  output  WORD_WIDTH  high word of the product.
- o_overflow  output  1  product does not fit in o_productLo (see arithmetic).

Behaviour:
- Reset (async, any state): state=IDLE, counter=0, o_busy=0, o_done=0, o_productLo=0, o_productHi=0, o_overflow=0, internal accumulators=0.
- States: IDLE, RUN, FIX, DONE.
- IDLE:
  - If i_start=1 at an edge: latch magA=|A| and magB=|B| (absolute value only if i_signed=1, else raw), latch negRes=i_signed&(A[msb]^B[msb]).
  - Clear acc_hi, load acc_lo=magB, counter=0, go to RUN.
  - Otherwise hold; outputs keep the last result.
- RUN, one step per cycle:
  - sum = {1'b0,acc_hi} + (acc_lo[0] ? magA : 0), a WORD_WIDTH+1-bit sum, carry-in 0.
  - {acc_hi,acc_lo} <= {sum,acc_lo} >> 1.
  - counter++.
  - After the WORD_WIDTH-th step (counter reaches WORD_WIDTH), go to FIX.
- FIX (1 cycle):
  - If negRes, two's-complement negate the 2W-bit {acc_hi,acc_lo}. Negating 0 yields 0.
  - Register into o_productHi/o_productLo and compute o_overflow. Go to DONE.
- DONE (1 cycle): o_done=1, then go to IDLE.
- Latency: i_start accepted at edge 0 → o_done high during the cycle after edge WORD_WIDTH+2 (34 edges for W=32). Issue rate is one operation per WORD_WIDTH+3 cycles.
- o_busy is registered: it goes high the cycle after start acceptance and low on the edge that leaves DONE.
- i_start when not IDLE (including DONE) is ignored entirely; it has no queueing and no effect on the running operation.
- Operands may change after acceptance with no effect.
- Result outputs change only in FIX and on reset. They hold through IDLE and through the next operation's RUN.
- Abs of the most-negative value (e.g. 0x80000000) is 2^(W-1), which is representable unsigned in magA/magB. No special case.
- Overflow:
  - unsigned: o_overflow = (o_productHi != 0).
  - signed: o_overflow = (o_productHi != {WORD_WIDTH{o_productLo[msb]}}).
- Reset mid-operation: aborts immediately; the next i_start after reset deasserts starts cleanly.

Test Plan (WORD_WIDTH=32):
- Unsigned 7×6, start at edge 0 → o_done pulse after edge 34, Lo=0x0000002A, Hi=0, overflow=0, o_busy high for exactly 34 cycles.
- Unsigned 0xFFFFFFFF×0xFFFFFFFF → Hi=0xFFFFFFFE, Lo=0x00000001, overflow=1.
- Signed −3×5 (0xFFFFFFFD, 0x00000005) → Hi=0xFFFFFFFF, Lo=0xFFFFFFF1, overflow=0. Signed −5×0 → Hi=Lo=0, overflow=0.
- Signed 0x80000000×0x80000000 → Hi=0x40000000, Lo=0, overflow=1. Signed 0x80000000×0xFFFFFFFF → Hi=0, Lo=0x80000000, overflow=1.
- Start 2×3. Pulse i_start with 9×9 at cycles 5 and 34 (DONE) → only one o_done, result Lo=6. Then a start in IDLE yields Lo=0x51.
- Start 100×100, assert i_rst at cycle 10 (async, mid-clock) → o_busy=0 and all outputs 0 immediately, no o_done. After release, 4×4 → Lo=0x10 after 34 edges.

Source files
------------

// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier for MUL/MULH-class ops in the EX stage.
// One partial-product step per cycle; signed ops run on magnitudes.
module seq_multiplier #(
   parameter int WORD_WIDTH = 32,
   parameter int CNT_WIDTH  = $clog2(WORD_WIDTH) + 1
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_start,
   input  logic                  i_signed,
   input  logic [WORD_WIDTH-1:0] i_A,
   input  logic [WORD_WIDTH-1:0] i_B,
   output logic                  o_busy,
   output logic                  o_done,
   output logic [WORD_WIDTH-1:0] o_productLo,
   output logic [WORD_WIDTH-1:0] o_productHi,
   output logic                  o_overflow
);

   localparam int W = WORD_WIDTH;
   localparam logic [CNT_WIDTH-1:0] LAST =
      CNT_WIDTH'(WORD_WIDTH - 1);
   localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      FIX,
      DONE
   } state_t;

   state_t state, state_nxt;

   logic [CNT_WIDTH-1:0] cnt;
   logic [W-1:0]         mag_a;
   logic [W-1:0]         acc_hi;
   logic [W-1:0]         acc_lo;
   logic                 neg_res;
   logic                 sgn;

   logic [W-1:0]   abs_a;
   logic [W-1:0]   abs_b;
   logic [W:0]     sum;
   logic [2*W-1:0] full;
   logic [2*W-1:0] fixed;
   logic [W-1:0]   fix_hi;
   logic [W-1:0]   fix_lo;
   logic           ovf;

   always_comb begin
      abs_a = i_A;
      abs_b = i_B;
      if (i_signed && i_A[W-1]) abs_a = -i_A;
      if (i_signed && i_B[W-1]) abs_b = -i_B;
      sum = {1'b0, acc_hi};
      if (acc_lo[0]) sum = {1'b0, acc_hi} + {1'b0, mag_a};
      full  = {acc_hi, acc_lo};
      fixed = neg_res ? -full : full;
      fix_hi = fixed[2*W-1:W];
      fix_lo = fixed[W-1:0];
      // Signed fit means the high word is pure sign extension.
      if (sgn) ovf = (fix_hi != {W{fix_lo[W-1]}});
      else     ovf = (fix_hi != '0);
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: if (i_start) state_nxt = RUN;
         RUN:  if (cnt == LAST) state_nxt = FIX;
         FIX:  state_nxt = DONE;
         DONE: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) state <= IDLE;
      else       state <= state_nxt;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         cnt         <= '0;
         mag_a       <= '0;
         acc_hi      <= '0;
         acc_lo      <= '0;
         neg_res     <= 1'b0;
         sgn         <= 1'b0;
         o_productLo <= '0;
         o_productHi <= '0;
         o_overflow  <= 1'b0;
         o_busy      <= 1'b0;
         o_done      <= 1'b0;
      end else begin
         o_busy <= (state_nxt != IDLE);
         o_done <= (state == DONE);
         unique case (state)
            IDLE: begin
               if (i_start) begin
                  mag_a   <= abs_a;
                  acc_lo  <= abs_b;
                  acc_hi  <= '0;
                  cnt     <= '0;
                  sgn     <= i_signed;
                  neg_res <= i_signed & (i_A[W-1] ^ i_B[W-1]);
               end
            end
            RUN: begin
               {acc_hi, acc_lo} <= {sum, acc_lo[W-1:1]};
               cnt <= cnt + ONE;
            end
            FIX: begin
               o_productHi <= fix_hi;
               o_productLo <= fix_lo;
               o_overflow  <= ovf;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed bench for seq_multiplier (W=32): products, latency,
// ignored starts and asynchronous abort.
module tb_seq_multiplier;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        sgn;
   logic [31:0] a;
   logic [31:0] b;
   logic        busy;
   logic        done;
   logic [31:0] lo;
   logic [31:0] hi;
   logic        ovf;

   int checks = 0;
   int errors = 0;

   seq_multiplier #(.WORD_WIDTH(32)) dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_start     (start),
      .i_signed    (sgn),
      .i_A         (a),
      .i_B         (b),
      .o_busy      (busy),
      .o_done      (done),
      .o_productLo (lo),
      .o_productHi (hi),
      .o_overflow  (ovf)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag,
                        input logic [63:0] got,
                        input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic run_op(input string tag,
                         input logic s,
                         input logic [31:0] opa,
                         input logic [31:0] opb,
                         input logic [31:0] exp_hi,
                         input logic [31:0] exp_lo,
                         input logic exp_ovf);
      int lat;
      int nbusy;
      @(negedge clk);
      sgn = s; a = opa; b = opb; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      a = $urandom;
      b = $urandom;
      sgn = ~s;
      lat = 0;
      nbusy = busy ? 1 : 0;
      while (!done && lat < 100) begin
         @(posedge clk);
         lat++;
         #1;
         if (busy) nbusy++;
      end
      check({tag, " latency"}, 64'(lat), 64'd34);
      check({tag, " busy"}, 64'(nbusy), 64'd34);
      check({tag, " hi"}, 64'(hi), 64'(exp_hi));
      check({tag, " lo"}, 64'(lo), 64'(exp_lo));
      check({tag, " ovf"}, 64'(ovf), 64'(exp_ovf));
      @(posedge clk);
      #1;
      check({tag, " pulse"}, 64'(done), 64'd0);
   endtask

   initial begin
      int ndone;
      logic [31:0] lo_seen;
      rst = 1'b1; start = 1'b0; sgn = 1'b0;
      a = '0; b = '0;
      #12;
      check("rst busy", 64'(busy), 64'd0);
      check("rst done", 64'(done), 64'd0);
      check("rst lo", 64'(lo), 64'd0);
      check("rst hi", 64'(hi), 64'd0);
      check("rst ovf", 64'(ovf), 64'd0);
      @(negedge clk);
      rst = 1'b0;

      run_op("u7x6", 1'b0, 32'd7, 32'd6,
             32'h0, 32'h2A, 1'b0);
      run_op("umax", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
             32'hFFFF_FFFE, 32'h1, 1'b1);
      run_op("s-3x5", 1'b1, 32'hFFFF_FFFD, 32'd5,
             32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
      run_op("s-5x0", 1'b1, 32'hFFFF_FFFB, 32'd0,
             32'h0, 32'h0, 1'b0);
      run_op("sminsq", 1'b1, 32'h8000_0000, 32'h8000_0000,
             32'h4000_0000, 32'h0, 1'b1);
      run_op("sminx-1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF,
             32'h0, 32'h8000_0000, 1'b1);
      run_op("u3x5", 1'b0, 32'd3, 32'd5,
             32'h0, 32'd15, 1'b0);

      // 2x3 with 9x9 requests while busy (edge 5 and edge 34 in DONE)
      @(negedge clk);
      sgn = 1'b0; a = 32'd2; b = 32'd3; start = 1'b1;
      @(posedge clk);
      ndone = 0;
      lo_seen = '0;
      for (int e = 1; e <= 45; e++) begin
         @(negedge clk);
         start = (e == 5 || e == 34);
         a = 32'd9; b = 32'd9;
         @(posedge clk);
         #1;
         if (done) begin
            ndone++;
            lo_seen = lo;
         end
      end
      start = 1'b0;
      check("ign ndone", 64'(ndone), 64'd1);
      check("ign lo", 64'(lo_seen), 64'd6);
      check("ign busy", 64'(busy), 64'd0);
      run_op("u9x9", 1'b0, 32'd9, 32'd9,
             32'h0, 32'h51, 1'b0);

      // abort 100x100 with an asynchronous reset mid-cycle
      @(negedge clk);
      sgn = 1'b0; a = 32'd100; b = 32'd100; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (9) @(posedge clk);
      #3 rst = 1'b1;
      #1;
      check("abort busy", 64'(busy), 64'd0);
      check("abort done", 64'(done), 64'd0);
      check("abort lo", 64'(lo), 64'd0);
      check("abort hi", 64'(hi), 64'd0);
      check("abort ovf", 64'(ovf), 64'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      ndone = 0;
      for (int e = 0; e < 40; e++) begin
         @(posedge clk);
         #1;
         if (done || busy) ndone++;
      end
      check("abort quiet", 64'(ndone), 64'd0);
      run_op("u4x4", 1'b0, 32'd4, 32'd4,
             32'h0, 32'h10, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
